// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// - Default register index width.
// - Bit layout of a packed scoreboard entry {valid, dst}.
// - Controller mode encoding and the bundle of buffer enables/flushes.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_INDEX_BIT_WIDTH_DEFAULT = 4;

    // Packed scoreboard entry is {valid, dst}: dst occupies [w-1:0], valid sits just above it.
    localparam int SB_DST_LSB = 0;

    function automatic int sb_valid_pos(input int w);
        return w;
    endfunction

    typedef enum logic [2:0] {
        MODE_RESET,
        MODE_FREEZE,
        MODE_REDIRECT,
        MODE_STALL,
        MODE_RUN
    } ctrl_mode_e;

    typedef struct packed {
        logic pc_wrt_en;
        logic if_dec_en;
        logic dec_exe_en;
        logic exe_mem_en;
        logic mem_wb_en;
        logic if_dec_flush;
        logic dec_exe_flush;
    } ctrl_out_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_sb_stage.sv
// One scoreboard entry {valid, dst} for a single pipeline stage.
// Ports:
//   clk, reset        - clock, synchronous active-high reset (clears entry)
//   en                - load entry_in on the rising edge
//   entry_in          - next {valid, dst}
//   idx_a, idx_b      - register indices to compare against
//   entry             - current {valid, dst}
//   match_a, match_b  - entry valid and dst equals idx_a / idx_b
module hazard_sb_stage
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int W = REG_INDEX_BIT_WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W:0]   entry_in,
    input  logic [W-1:0] idx_a,
    input  logic [W-1:0] idx_b,
    output logic [W:0]   entry,
    output logic         match_a,
    output logic         match_b
);

    localparam int VPOS = sb_valid_pos(W);

    logic [W:0] entry_q;
    logic [W:0] entry_d;

    always_comb begin
        entry_d = entry_q;
        if (en) begin
            entry_d = entry_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry   = entry_q;
    assign match_a = entry_q[VPOS] && (entry_q[SB_DST_LSB +: W] == idx_a);
    assign match_b = entry_q[VPOS] && (entry_q[SB_DST_LSB +: W] == idx_b);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline (IF, DEC, EXE, MEM, WB).
// Tracks in-flight destinations for EXE/MEM/WB, stalls DEC on RAW hazards,
// squashes wrong-path work on a redirect, and counts stall/flush cycles.
// Ports:
//   clk, reset                         - clock, synchronous active-high reset
//   dec_src1/2_idx, dec_src1/2_use     - sources read by the DEC instruction
//   dec_dst_idx, dec_reg_wrt_en        - destination written by the DEC instruction
//   exe_redirect                       - taken branch / JAL resolved in EXE
//   mem_busy                           - freeze request from memory / IO
//   pc_wrt_en .. mem_wb_en             - PC and pipeline buffer enables
//   if_dec_flush, dec_exe_flush        - load NOP / bubble on the next edge
//   stall_cnt, flush_cnt               - saturating debug counters
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_INDEX_BIT_WIDTH = REG_INDEX_BIT_WIDTH_DEFAULT,
    parameter int CNT_BITS            = 32,
    parameter bit R0_IS_ZERO          = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src1_idx,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src2_idx,
    input  logic                           dec_src1_use,
    input  logic                           dec_src2_use,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_dst_idx,
    input  logic                           dec_reg_wrt_en,
    input  logic                           exe_redirect,
    input  logic                           mem_busy,
    output logic                           pc_wrt_en,
    output logic                           if_dec_en,
    output logic                           dec_exe_en,
    output logic                           exe_mem_en,
    output logic                           mem_wb_en,
    output logic                           if_dec_flush,
    output logic                           dec_exe_flush,
    output logic [CNT_BITS-1:0]            stall_cnt,
    output logic [CNT_BITS-1:0]            flush_cnt
);

    localparam int W = REG_INDEX_BIT_WIDTH;

    // Stage 0 = EXE, 1 = MEM, 2 = WB. WB counts as a hazard: no write-through in the regfile.
    logic [W:0] sb_entry [3];
    logic [W:0] sb_in    [3];
    logic [2:0] match1;
    logic [2:0] match2;
    logic       sb_en;
    logic       src1_live;
    logic       src2_live;
    logic       raw_stall;
    logic       exe_valid_in;
    logic       unused_wb_entry;

    assign sb_en     = !mem_busy;
    assign src1_live = dec_src1_use && (!R0_IS_ZERO || (dec_src1_idx != '0));
    assign src2_live = dec_src2_use && (!R0_IS_ZERO || (dec_src2_idx != '0));
    assign raw_stall = (src1_live && (|match1)) || (src2_live && (|match2));

    // A stalled or wrong-path DEC instruction enters EXE as a bubble.
    assign exe_valid_in = dec_reg_wrt_en && !raw_stall && !exe_redirect
                          && (!R0_IS_ZERO || (dec_dst_idx != '0));

    assign sb_in[0] = {exe_valid_in, dec_dst_idx};
    assign sb_in[1] = sb_entry[0];
    assign sb_in[2] = sb_entry[1];

    // The WB entry only feeds the comparators; nothing shifts out of it.
    assign unused_wb_entry = ^sb_entry[2];

    for (genvar i = 0; i < 3; i++) begin : g_sb
        hazard_sb_stage #(.W(W)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .en      (sb_en),
            .entry_in(sb_in[i]),
            .idx_a   (dec_src1_idx),
            .idx_b   (dec_src2_idx),
            .entry   (sb_entry[i]),
            .match_a (match1[i]),
            .match_b (match2[i])
        );
    end

    ctrl_mode_e mode;
    ctrl_out_t  ctrl;

    always_comb begin
        mode = MODE_RUN;
        if (reset) begin
            mode = MODE_RESET;
        end else if (mem_busy) begin
            mode = MODE_FREEZE;
        end else if (exe_redirect) begin
            mode = MODE_REDIRECT;
        end else if (raw_stall) begin
            mode = MODE_STALL;
        end
    end

    always_comb begin
        ctrl = '{default: 1'b1};
        unique case (mode)
            MODE_RESET, MODE_REDIRECT: ctrl = '{default: 1'b1};
            MODE_FREEZE:               ctrl = '{default: 1'b0};
            MODE_STALL: begin
                // Hold PC and IF_DEC, push a bubble into EXE, let older work drain.
                ctrl.pc_wrt_en    = 1'b0;
                ctrl.if_dec_en    = 1'b0;
                ctrl.if_dec_flush = 1'b0;
            end
            default: begin
                ctrl.if_dec_flush  = 1'b0;
                ctrl.dec_exe_flush = 1'b0;
            end
        endcase
    end

    assign pc_wrt_en     = ctrl.pc_wrt_en;
    assign if_dec_en     = ctrl.if_dec_en;
    assign dec_exe_en    = ctrl.dec_exe_en;
    assign exe_mem_en    = ctrl.exe_mem_en;
    assign mem_wb_en     = ctrl.mem_wb_en;
    assign if_dec_flush  = ctrl.if_dec_flush;
    assign dec_exe_flush = ctrl.dec_exe_flush;

    logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_BITS-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (raw_stall && !exe_redirect && !mem_busy && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_BITS'(1);
        end
        if (exe_redirect && !mem_busy && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int W = 4;

    // Output pattern {pc, if_dec_en, dec_exe_en, exe_mem_en, mem_wb_en, if_dec_flush, dec_exe_flush}
    localparam logic [6:0] RST = 7'b1111111;
    localparam logic [6:0] RUN = 7'b1111100;
    localparam logic [6:0] STL = 7'b0011101;
    localparam logic [6:0] RDR = 7'b1111111;
    localparam logic [6:0] BSY = 7'b0000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [W-1:0] dec_src1_idx, dec_src2_idx, dec_dst_idx;
    logic         dec_src1_use, dec_src2_use, dec_reg_wrt_en;
    logic         exe_redirect, mem_busy;

    logic        pc_wrt_en, if_dec_en, dec_exe_en, exe_mem_en, mem_wb_en;
    logic        if_dec_flush, dec_exe_flush;
    logic [31:0] stall_cnt, flush_cnt;

    logic        z_pc_wrt_en, z_if_dec_en, z_dec_exe_en, z_exe_mem_en, z_mem_wb_en;
    logic        z_if_dec_flush, z_dec_exe_flush;
    logic [1:0]  z_stall_cnt, z_flush_cnt;

    pipeline_hazard_ctrl #(.REG_INDEX_BIT_WIDTH(W), .CNT_BITS(32), .R0_IS_ZERO(1'b0)) dut (
        .clk(clk), .reset(reset),
        .dec_src1_idx(dec_src1_idx), .dec_src2_idx(dec_src2_idx),
        .dec_src1_use(dec_src1_use), .dec_src2_use(dec_src2_use),
        .dec_dst_idx(dec_dst_idx), .dec_reg_wrt_en(dec_reg_wrt_en),
        .exe_redirect(exe_redirect), .mem_busy(mem_busy),
        .pc_wrt_en(pc_wrt_en), .if_dec_en(if_dec_en), .dec_exe_en(dec_exe_en),
        .exe_mem_en(exe_mem_en), .mem_wb_en(mem_wb_en),
        .if_dec_flush(if_dec_flush), .dec_exe_flush(dec_exe_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Second instance: r0 hardwired to zero and 2-bit counters to reach saturation quickly.
    pipeline_hazard_ctrl #(.REG_INDEX_BIT_WIDTH(W), .CNT_BITS(2), .R0_IS_ZERO(1'b1)) dut_z (
        .clk(clk), .reset(reset),
        .dec_src1_idx(dec_src1_idx), .dec_src2_idx(dec_src2_idx),
        .dec_src1_use(dec_src1_use), .dec_src2_use(dec_src2_use),
        .dec_dst_idx(dec_dst_idx), .dec_reg_wrt_en(dec_reg_wrt_en),
        .exe_redirect(exe_redirect), .mem_busy(mem_busy),
        .pc_wrt_en(z_pc_wrt_en), .if_dec_en(z_if_dec_en), .dec_exe_en(z_dec_exe_en),
        .exe_mem_en(z_exe_mem_en), .mem_wb_en(z_mem_wb_en),
        .if_dec_flush(z_if_dec_flush), .dec_exe_flush(z_dec_exe_flush),
        .stall_cnt(z_stall_cnt), .flush_cnt(z_flush_cnt)
    );

    typedef struct {
        logic         rst;
        logic [W-1:0] s1;
        logic         u1;
        logic [W-1:0] s2;
        logic         u2;
        logic [W-1:0] dst;
        logic         we;
        logic         rd;
        logic         bz;
        logic [6:0]   out;
        int           sc;
        int           fc;
        logic         zpc;
        int           zsc;
        int           zfc;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(logic rst, int s1, logic u1, int s2, logic u2, int dst,
                                logic we, logic rd, logic bz, logic [6:0] out,
                                int sc, int fc, logic zpc, int zsc, int zfc);
        vec_t v;
        v.rst = rst; v.s1 = W'(s1); v.u1 = u1; v.s2 = W'(s2); v.u2 = u2;
        v.dst = W'(dst); v.we = we; v.rd = rd; v.bz = bz; v.out = out;
        v.sc = sc; v.fc = fc; v.zpc = zpc; v.zsc = zsc; v.zfc = zfc;
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        reset          = v.rst;
        dec_src1_idx   = v.s1;
        dec_src1_use   = v.u1;
        dec_src2_idx   = v.s2;
        dec_src2_use   = v.u2;
        dec_dst_idx    = v.dst;
        dec_reg_wrt_en = v.we;
        exe_redirect   = v.rd;
        mem_busy       = v.bz;
    endtask

    function automatic logic [6:0] outs();
        return {pc_wrt_en, if_dec_en, dec_exe_en, exe_mem_en, mem_wb_en,
                if_dec_flush, dec_exe_flush};
    endfunction

    initial begin
        vec_t e;
        vec_t idle;
        int   cyc;
        bit   done;

        //           rst s1 u1 s2 u2 dst we rd bz out  sc fc zpc zsc zfc
        // reset, then idle; reading r0 right after reset proves all entries invalid
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, RUN, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, RUN, 0, 0, 1, 0, 0));
        // back-to-back: A dst=3, B src1=3 -> 3 stall cycles
        tbl.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 0, RUN, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 3, 1, 0, 0, 7, 1, 0, 0, STL, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3, 1, 0, 0, 7, 1, 0, 0, STL, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 3, 1, 0, 0, 7, 1, 0, 0, STL, 2, 0, 0, 2, 0));
        tbl.push_back(mk(0, 3, 1, 0, 0, 7, 1, 0, 0, RUN, 3, 0, 1, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, RUN, 3, 0, 1, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, RUN, 3, 0, 1, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, RUN, 3, 0, 1, 3, 0));
        // two apart: A dst=5, C independent, B src2=5 -> 2 stall cycles
        tbl.push_back(mk(0, 0, 0, 0, 0, 5, 1, 0, 0, RUN, 3, 0, 1, 3, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 6, 1, 0, 0, RUN, 3, 0, 1, 3, 0));
        tbl.push_back(mk(0, 0, 0, 5, 1, 8, 0, 0, 0, STL, 3, 0, 0, 3, 0));
        tbl.push_back(mk(0, 0, 0, 5, 1, 8, 0, 0, 0, STL, 4, 0, 0, 3, 0));
        tbl.push_back(mk(0, 0, 0, 5, 1, 8, 0, 0, 0, RUN, 5, 0, 1, 3, 0));
        // redirect over a dependent DEC instruction; its dst=10 must enter EXE invalid
        tbl.push_back(mk(0, 0, 0, 0, 0, 9, 1, 0, 0, RUN, 5, 0, 1, 3, 0));
        tbl.push_back(mk(0, 9, 1, 0, 0, 10, 1, 1, 0, RDR, 5, 0, 1, 3, 0));
        tbl.push_back(mk(0, 10, 1, 0, 0, 0, 0, 0, 0, RUN, 5, 1, 1, 3, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, RUN, 5, 1, 1, 3, 1));
        // mem_busy for 4 cycles in front of a 2-cycle stall (one busy cycle also redirects)
        tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 0, RUN, 5, 1, 1, 3, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, RUN, 5, 1, 1, 3, 1));
        tbl.push_back(mk(0, 2, 1, 0, 0, 0, 0, 0, 1, BSY, 5, 1, 0, 3, 1));
        tbl.push_back(mk(0, 2, 1, 0, 0, 0, 0, 0, 1, BSY, 5, 1, 0, 3, 1));
        tbl.push_back(mk(0, 2, 1, 0, 0, 0, 0, 1, 1, BSY, 5, 1, 0, 3, 1));
        tbl.push_back(mk(0, 2, 1, 0, 0, 0, 0, 0, 1, BSY, 5, 1, 0, 3, 1));
        tbl.push_back(mk(0, 2, 1, 0, 0, 0, 0, 0, 0, STL, 5, 1, 0, 3, 1));
        tbl.push_back(mk(0, 2, 1, 0, 0, 0, 0, 0, 0, STL, 6, 1, 0, 3, 1));
        tbl.push_back(mk(0, 2, 1, 0, 0, 0, 0, 0, 0, RUN, 7, 1, 1, 3, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, RUN, 7, 1, 1, 3, 1));
        // reset mid-stall clears scoreboard and counters
        tbl.push_back(mk(0, 0, 0, 0, 0, 4, 1, 0, 0, RUN, 7, 1, 1, 3, 1));
        tbl.push_back(mk(0, 4, 1, 0, 0, 0, 0, 0, 0, STL, 7, 1, 0, 3, 1));
        tbl.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 0, RST, 8, 1, 1, 3, 1));
        tbl.push_back(mk(0, 4, 1, 0, 0, 0, 0, 0, 0, RUN, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, RUN, 0, 0, 1, 0, 0));
        // A dst=0, B src1=0: stalls 3 cycles unless r0 is hardwired
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, RUN, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 11, 0, 0, 0, STL, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 11, 0, 0, 0, STL, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 11, 0, 0, 0, STL, 2, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 11, 0, 0, 0, RUN, 3, 0, 1, 0, 0));
        // four redirects: 2-bit flush counter saturates at 3
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, RDR, 3, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, RDR, 3, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, RDR, 3, 2, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, RDR, 3, 3, 1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, RUN, 3, 4, 1, 0, 3));

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, RUN, 0, 0, 1, 0, 0);
        drive(tbl[0]);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i]);
            exp_q.push_back(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("v%0d_outs", i), longint'(outs()), longint'(e.out));
            check($sformatf("v%0d_stall_cnt", i), longint'(stall_cnt), longint'(e.sc));
            check($sformatf("v%0d_flush_cnt", i), longint'(flush_cnt), longint'(e.fc));
            check($sformatf("v%0d_z_pc", i), longint'(z_pc_wrt_en), longint'(e.zpc));
            check($sformatf("v%0d_z_stall_cnt", i), longint'(z_stall_cnt), longint'(e.zsc));
            check($sformatf("v%0d_z_flush_cnt", i), longint'(z_flush_cnt), longint'(e.zfc));
        end

        // Hand-written: A dst=12 then B src2=12; wait (bounded) for PC to resume.
        @(posedge clk);
        #1;
        drive(idle);
        dec_dst_idx    = 4'd12;
        dec_reg_wrt_en = 1'b1;
        @(posedge clk);
        #1;
        drive(idle);
        dec_src2_idx = 4'd12;
        dec_src2_use = 1'b1;
        cyc  = 0;
        done = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            if (pc_wrt_en) begin
                done = 1'b1;
            end else begin
                check($sformatf("seq_stall%0d_dxf", k), longint'(dec_exe_flush), 1);
                cyc++;
                @(posedge clk);
                #1;
            end
        end
        check("seq_release_seen", longint'(done), 1);
        check("seq_stall_len", longint'(cyc), 3);
        check("seq_stall_cnt", longint'(stall_cnt), 6);
        check("seq_z_stall_cnt_sat", longint'(z_stall_cnt), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Stall/flush controller for the 5-stage pipeline (IF, DEC, EXE, MEM, WB). It replaces the hard-wired buffer enables.
- Keeps its own scoreboard of in-flight destination registers for EXE, MEM and WB.
- Detects RAW hazards against the instruction in DEC and generates the PC and pipeline-buffer enables.
- Squashes wrong-path instructions on a taken branch or JAL, and counts stall and flush cycles for debug.

Parameters:
- REG_INDEX_BIT_WIDTH, 4: register index width.
- CNT_BITS, 32: width of the performance counters.
- R0_IS_ZERO, 0: when 1, a source or destination index of 0 never creates a hazard.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- dec_src1_idx  in  REG_INDEX_BIT_WIDTH  src1 index of the instruction in DEC.
- dec_src2_idx  in  REG_INDEX_BIT_WIDTH  src2 index of the instruction in DEC.
- dec_src1_use  in  1  DEC instruction reads src1.
- dec_src2_use  in  1  DEC instruction reads src2.
- dec_dst_idx  in  REG_INDEX_BIT_WIDTH  destination index of the DEC instruction.
- dec_reg_wrt_en  in  1  DEC instruction writes the register file.
- exe_redirect  in  1  EXE resolved a taken branch or JAL (next_pc_mux from EXE).
- mem_busy  in  1  external freeze request from data memory or IO.
- pc_wrt_en  out  1  PC register write enable.
- if_dec_en  out  1  IF_DEC buffer enable.
- dec_exe_en  out  1  DEC_EXE buffer enable.
- exe_mem_en  out  1  EXE_MEM buffer enable.
- mem_wb_en  out  1  MEM_WB buffer enable.
- if_dec_flush  out  1  load NOP into IF_DEC on the next edge.
- dec_exe_flush  out  1  load a bubble (reg_wrt_en=0, mem_wrt_en=0) into DEC_EXE on the next edge.
- stall_cnt  out  CNT_BITS  cycles with a RAW stall.
- flush_cnt  out  CNT_BITS  redirects taken.

Behaviour:
- Scoreboard: three entries {valid, dst} for EXE, MEM and WB. It is updated only on rising clk.
- The register file has no write-through, so the WB entry also counts as a hazard. Forwarding is not used.
- Per-source hazard: use AND (R0_IS_ZERO==0 OR idx!=0) AND there exists an entry e with e.valid AND e.dst==idx.
- raw_stall = hazard(src1) OR hazard(src2). It is combinational, with zero-cycle latency from the DEC inputs.
- Output priority, highest first:
  - reset: all enables 1, both flushes 1, counters held at 0.
  - mem_busy: all enables 0, flushes 0, scoreboard holds, counters hold.
  - exe_redirect: all enables 1, if_dec_flush=1, dec_exe_flush=1. Any raw_stall is ignored, because the DEC instruction is wrong-path.
  - raw_stall: pc_wrt_en=0, if_dec_en=0, dec_exe_en=1, dec_exe_flush=1, exe_mem_en=1, mem_wb_en=1.
  - otherwise: all enables 1, flushes 0.
- Scoreboard update, when not reset and not mem_busy:
  - WB <= MEM; MEM <= EXE.
  - EXE <= {dec_reg_wrt_en AND NOT raw_stall AND NOT exe_redirect, dec_dst_idx}.
  - With R0_IS_ZERO=1, a dst of 0 enters as invalid.
- Reset clears all entries to invalid and dst to 0.
- Counters:
  - stall_cnt increments when raw_stall AND NOT exe_redirect AND NOT mem_busy.
  - flush_cnt increments when exe_redirect AND NOT mem_busy.
  - Both saturate at all-ones; they do not wrap.
  - Reset value is 0.
- Reset asserted mid-stall or mid-flush takes effect on the next edge. Scoreboard and counters are 0 the cycle after.
- Maximum RAW stall: 3 cycles (producer in EXE). Stall releases the cycle after the producer leaves WB.
- Simultaneous redirect and mem_busy: mem_busy wins. The redirect must be held by EXE, because EXE is frozen.

Decomposition:
- Shared header cpu_defs.vh holds:
  - REG_INDEX_BIT_WIDTH;
  - the bit positions of the packed scoreboard entry {valid, dst};
  - the OP1_* opcode constants.
- One sub-module, hazard_sb_stage: a single {valid, dst} register with enable, sync reset and a comparator output match(idx). It is instantiated three times.
- Priority logic and counters stay in the top module.

Test Plan:
- Reset held 2 cycles, then released with dec inputs idle: enables all 1, flushes 0, stall_cnt=0, flush_cnt=0; the cycle after release, all scoreboard entries are invalid.
- Back-to-back dependency: instruction A (dst=3, wrt_en=1), then instruction B (src1=3, use=1): raw_stall is asserted for exactly 3 cycles with pc_wrt_en=0 and dec_exe_flush=1; B proceeds on the 4th cycle; stall_cnt=3.
- Dependency 2 instructions apart (A dst=5, independent C, then B src2=5): stall lasts 2 cycles; stall_cnt=2.
- exe_redirect=1 while DEC holds a dependent instruction: no stall, if_dec_flush=dec_exe_flush=1, all enables 1, the EXE entry loaded as invalid, flush_cnt=1, stall_cnt unchanged.
- mem_busy=1 for 4 cycles during a pending 2-cycle stall: all enables 0, scoreboard frozen, counters frozen; after release, the stall completes with its remaining cycles.
- R0_IS_ZERO=1, A dst=0 followed by B src1=0: no stall; with R0_IS_ZERO=0 the same sequence stalls 3 cycles.
